johnson_counter: RTL and testbench
==================================

JOHNSON_COUNTER -- requirements
Module: johnson_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter register width in bits; legal range 2..16.
REQ-002 Derived localparam SEQ_LEN = 2*WIDTH, number of legal states; PHASE_W = clog2(SEQ_LEN).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-006 data_out  output  WIDTH  Johnson counter state, registered.
REQ-007 phase  output  PHASE_W  index 0..SEQ_LEN-1 of the current state in the legal sequence, combinational from data_out.
REQ-008 wrap  output  1  high while data_out is the last legal state (MSB=1, all others 0), combinational.
REQ-009 illegal  output  1  registered flag, high for one cycle after a correction from an illegal state.

Function
REQ-010 Each rising clk edge with reset deasserted: data_out <= {data_out[WIDTH-2:0], ~data_out[WIDTH-1]} (shift left, inverted MSB into LSB).
REQ-011 WIDTH=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000; period 8 cycles.
REQ-012 Legal states: k ones packed at LSB (k=0..WIDTH), or j ones packed at MSB with zeros below (j=1..WIDTH-1).
REQ-013 phase: k for LSB-packed states with k ones; WIDTH + (WIDTH - j) for MSB-packed states with j ones; e.g. 1110 -> 5, 1000 -> 7.
REQ-014 Self-correction: if data_out holds an illegal state at a clock edge, next data_out = all zeros and illegal <= 1; otherwise illegal <= 0.
REQ-015 While data_out is illegal, phase = 0 and wrap = 0.
REQ-016 Wrap-around: the edge after wrap=1 yields all zeros with illegal=0; no extra cycle is inserted.
REQ-017 No enable: the counter advances on every clock edge while out of reset; latency from reset release to first change is one edge.

Reset
REQ-018 reset=0 forces data_out = all zeros and illegal = 0 immediately, independent of clk.
REQ-019 Reset asserted mid-sequence takes effect immediately; the sequence restarts from 0000 at the first edge after release.
REQ-020 Release is sampled at clk edges; the first rising edge with reset=1 produces 0001 (WIDTH=4).

Structure
REQ-021 A shared package johnson_pkg holds the default WIDTH, the SEQ_LEN/PHASE_W derivation functions, and a function computing the next Johnson state.
REQ-022 One sub-module, johnson_decode, combinationally maps a state to {legal, phase, wrap}; the top instantiates it once and holds the state and illegal registers.
REQ-023 Only data_out and illegal are registered; there are no latches and no combinational loops.

Verification
REQ-024 reset=0 at t=0, clk 10 ns period, release at 8 ns -> data_out=0000 before the first edge after release, then 0001 at 15 ns, 0011 at 25 ns, 0111, 1111, 1110, 1100, 1000, and 0000 at 85 ns.
REQ-025 Run 20 cycles -> phase increments 0..7 modulo 8, wrap high exactly when data_out=1000, illegal stays 0.
REQ-026 Force data_out=0101 for one edge, then release -> next data_out=0000, illegal=1 for exactly one cycle, then 0001 with illegal=0.
REQ-027 Assert reset between clock edges while data_out=0111 -> data_out=0000 without waiting for clk; after release the next edge gives 0001.
REQ-028 WIDTH=2 and WIDTH=8 builds -> periods of 4 and 16 cycles respectively, with phase and wrap consistent with REQ-013 and REQ-008.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared Johnson counter definitions: default width, derived sizes, next-state function.
// No latency (package only); no backpressure.
package johnson_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int MAX_WIDTH = 16;

    function automatic int seq_len(input int w);
        return 2 * w;
    endfunction

    function automatic int phase_w(input int w);
        return $clog2(2 * w);
    endfunction

    // Shift left and feed the inverted MSB back into bit 0; bits at or above w stay zero.
    function automatic logic [MAX_WIDTH-1:0] next_state(input logic [MAX_WIDTH-1:0] s,
                                                         input int w);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 1; i < MAX_WIDTH; i++) begin
            if (i < w) r[i] = s[i-1];
        end
        r[0] = ~s[w-1];
        return r;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Maps a counter state to {legal, phase, wrap}.
// Purely combinational, zero latency; no backpressure.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int SEQ_LEN = seq_len(WIDTH),
    localparam int PHASE_W = phase_w(WIDTH)
) (
    input  logic [WIDTH-1:0]   state,
    output logic               legal,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap
);

    logic [WIDTH-1:0] inv;
    logic             lsb_packed;
    logic             msb_packed;
    int               ones;

    assign inv = ~state;

    // A run of ones starting at bit 0 has no bit in common with its own increment.
    assign lsb_packed = ((state & (state + 1'b1)) == '0);
    assign msb_packed = ((inv & (inv + 1'b1)) == '0);
    assign legal      = lsb_packed | msb_packed;

    always_comb begin
        ones  = $countones(state);
        phase = '0;
        if (lsb_packed) begin
            phase = PHASE_W'(ones);
        end else if (msb_packed) begin
            phase = PHASE_W'(2 * WIDTH - ones);
        end
    end

    assign wrap = legal && (phase == PHASE_W'(SEQ_LEN - 1));

endmodule

// File: rtl/johnson_counter.sv
// Self-correcting Johnson counter with phase index, wrap and illegal-state flag.
// data_out/illegal registered (1 edge); phase/wrap combinational; no backpressure, advances every edge.
module johnson_counter
    import johnson_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int PHASE_W = phase_w(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [WIDTH-1:0]   data_out,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic               illegal
);

    logic                 legal;
    logic [MAX_WIDTH-1:0] nxt_full;
    logic                 nxt_unused;

    assign nxt_full   = next_state(MAX_WIDTH'(data_out), WIDTH);
    assign nxt_unused = ^nxt_full;

    johnson_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .state (data_out),
        .legal (legal),
        .phase (phase),
        .wrap  (wrap)
    );

    // An illegal state is dropped straight back to zero rather than walked out of.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            illegal  <= 1'b0;
        end else if (!legal) begin
            data_out <= '0;
            illegal  <= 1'b1;
        end else begin
            data_out <= nxt_full[WIDTH-1:0];
            illegal  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_johnson_counter.sv
// Bench for johnson_counter at WIDTH 2, 4 and 8 against a phase-index reference model.
module tb_johnson_counter;

    logic       clk;
    logic       reset;

    logic [1:0] d2;
    logic [1:0] ph2;
    logic       wr2, il2;
    logic [3:0] d4;
    logic [2:0] ph4;
    logic       wr4, il4;
    logic [7:0] d8;
    logic [3:0] ph8;
    logic       wr8, il8;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         p2, p4, p8;
    logic       ill4;
    logic [3:0] inj_val;

    johnson_counter #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .data_out(d2), .phase(ph2), .wrap(wr2), .illegal(il2)
    );
    johnson_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .data_out(d4), .phase(ph4), .wrap(wr4), .illegal(il4)
    );
    johnson_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .data_out(d8), .phase(ph8), .wrap(wr8), .illegal(il8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // State at position p of the sequence: p ones at the bottom while filling,
    // then (2w - p) ones left at the top while draining.
    function automatic int exp_state(input int w, input int p);
        int j;
        if (p <= w) return (1 << p) - 1;
        j = 2 * w - p;
        return ((1 << j) - 1) << (w - j);
    endfunction

    function automatic int idx_of(input int w, input int s);
        for (int p = 0; p < 2 * w; p++) begin
            if (exp_state(w, p) == s) return p;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_duts();
        check("w2_data",    32'(d2),  32'(exp_state(2, p2)));
        check("w2_phase",   32'(ph2), 32'(p2));
        check("w2_wrap",    32'(wr2), 32'(p2 == 3));
        check("w2_illegal", 32'(il2), 32'(0));
        check("w4_data",    32'(d4),  32'(exp_state(4, p4)));
        check("w4_phase",   32'(ph4), 32'(p4));
        check("w4_wrap",    32'(wr4), 32'(p4 == 7));
        check("w4_illegal", 32'(il4), 32'(ill4));
        check("w8_data",    32'(d8),  32'(exp_state(8, p8)));
        check("w8_phase",   32'(ph8), 32'(p8));
        check("w8_wrap",    32'(wr8), 32'(p8 == 15));
        check("w8_illegal", 32'(il8), 32'(0));
    endtask

    task automatic advance();
        p2   = (p2 + 1) % 4;
        p4   = (p4 + 1) % 8;
        p8   = (p8 + 1) % 16;
        ill4 = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        advance();
        @(negedge clk);
        check_duts();
    endtask

    // Called at a falling edge; the value is present in the register at the next rising edge.
    task automatic inject(input logic [3:0] v);
        int idx;
        idx     = idx_of(4, int'(v));
        inj_val = v;
        force dut4.data_out = inj_val;
        #1;
        check("inj_phase", 32'(ph4), (idx < 0) ? 32'(0) : 32'(idx));
        check("inj_wrap",  32'(wr4), 32'(idx == 7));
        #3;
        release dut4.data_out;
        @(posedge clk);
        advance();
        p4   = (idx < 0) ? 0 : (idx + 1) % 8;
        ill4 = (idx < 0);
        @(negedge clk);
        check_duts();
    endtask

    // Called at a falling edge; reset asserts and releases between rising edges.
    task automatic reset_pulse(input int off, input int hold);
        #off;
        reset = 1'b0;
        #1;
        p2 = 0; p4 = 0; p8 = 0; ill4 = 1'b0;
        check_duts();
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check_duts();
        end
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        p2 = 0; p4 = 0; p8 = 0; ill4 = 1'b0;
        inj_val = '0;

        #1;
        check_duts();
        #7;
        reset = 1'b1;
        @(negedge clk);
        check_duts();

        step();
        check("first_edge_w4", 32'(d4), 32'(4'b0001));
        repeat (19) step();

        step();
        inject(4'b0101);
        step();
        check("after_illegal_w4", 32'(d4), 32'(4'b0001));

        while (p4 != 3) step();
        check("pre_reset_w4", 32'(d4), 32'(4'b0111));
        reset_pulse(2, 0);
        step();
        check("post_reset_w4", 32'(d4), 32'(4'b0001));

        repeat (12) begin
            repeat ($urandom_range(1, 20)) step();
            case ($urandom_range(0, 2))
                0:       inject(4'($urandom_range(0, 15)));
                1:       reset_pulse(int'($urandom_range(1, 2)), int'($urandom_range(0, 2)));
                default: step();
            endcase
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
